// File: rtl/uart_pkg.sv
// Shared UART constants, scheduler state encoding and baud divider helper.
package uart_pkg;

  localparam int unsigned UART_DATA_W     = 8;
  localparam int unsigned UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    HOLDOFF,
    IDLE,
    SEND,
    WAIT
  } uart_sched_state_t;

  function automatic int unsigned uart_clks_per_bit(input int unsigned freq,
                                                    input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin from ptr, or lowest-index-wins when
// UART_SCHED_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int unsigned  N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [IDX_W-1:0] cand;

`ifdef UART_SCHED_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
`ifdef UART_SCHED_FIXED_PRIO_EN
      cand = IDX_W'(k);
`else
      cand = IDX_W'((32'(ptr) + k) % N_REQ);
`endif
      if (req[cand] && !gnt_valid) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_transmitter among N_REQ byte producers, one byte per frame time.
// Define UART_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned NATIVE_CLK_FREQUENCY = 100000,
  parameter int unsigned BAUDRATE             = 9600,
  parameter int unsigned N_REQ                = 4,
  parameter int unsigned GAP_CYCLES           = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         tx_sending,
  output logic [0:UART_DATA_W-1]       tx_data,
  output logic                         busy,
  output logic [$clog2(N_REQ)-1:0]     grant_id
);

  localparam int unsigned IDX_W        = $clog2(N_REQ);
  localparam int unsigned CLKS_PER_BIT = uart_clks_per_bit(NATIVE_CLK_FREQUENCY, BAUDRATE);
  localparam int unsigned FRAME_CYCLES = UART_FRAME_BITS * CLKS_PER_BIT;
  localparam int unsigned PERIOD       = FRAME_CYCLES + GAP_CYCLES;
  localparam int unsigned CNT_W        = $clog2(FRAME_CYCLES + PERIOD);
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(FRAME_CYCLES - 1);
  // Transfer edge + SEND cycle + WAIT + IDLE cycle spans exactly PERIOD cycles.
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(PERIOD - 3);

  if (PERIOD < 3) begin : g_bad_period
    $error("uart_tx_scheduler: PERIOD must be at least 3");
  end
  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
    $error("uart_tx_scheduler: N_REQ must be in 2..16");
  end

  uart_sched_state_t      state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d, sel_byte;
  logic [IDX_W-1:0]       grant_id_q, grant_id_d, rr_ptr, gnt_idx;
  logic [N_REQ-1:0]       gnt;
  logic                   gnt_valid;

  assign rr_ptr = (grant_id_q == IDX_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid)
  );

  always_comb begin
    sel_byte = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) sel_byte = req_data[UART_DATA_W*i +: UART_DATA_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    req_ready  = '0;
    case (state_q)
      HOLDOFF, WAIT: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      IDLE: begin
        req_ready = gnt;
        if (gnt_valid) begin
          tx_data_d  = sel_byte;
          grant_id_d = gnt_idx;
          cnt_d      = WAIT_INIT;
          state_d    = SEND;
        end
      end
      SEND:    state_d = WAIT;
      default: state_d = HOLDOFF;
    endcase
  end

  // Reset lands in HOLDOFF so a frame cut short by reset can drain on the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HOLDOFF;
      cnt_q      <= HOLD_INIT;
      tx_data_q  <= '0;
      grant_id_q <= IDX_W'(N_REQ - 1);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign tx_sending = (state_q == SEND);
  assign busy       = (state_q != IDLE);
  assign tx_data    = tx_data_q;
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler (N_REQ=4, 100 cycles per frame, no gap).
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx_sending;
  logic [0:7]  tx_data;
  logic        busy;
  logic [1:0]  grant_id;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_scheduler #(
    .NATIVE_CLK_FREQUENCY(100000),
    .BAUDRATE            (9600),
    .N_REQ               (4),
    .GAP_CYCLES          (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_sending(tx_sending),
    .tx_data   (tx_data),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset(input logic [3:0] v);
    rst_n = 1'b0;
    req_valid = v;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  // Waits (bounded) for a transfer; edge_cyc is the cycle count of the transfer edge.
  task automatic wait_xfer(input int budget, output bit ok, output int idx,
                           output int edge_cyc, output logic [3:0] rdy);
    ok = 1'b0;
    idx = -1;
    edge_cyc = -1;
    rdy = '0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        rdy = req_ready;
        edge_cyc = cyc + 1;
        for (int i = 0; i < 4; i++) if (req_valid[i] & req_ready[i]) idx = i;
        ok = 1'b1;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    bit ok;
    int idx, e;
    logic [3:0] rdy;
    bit ready_seen;
    rst_n = 1'b0;
    req_valid = 4'b0001;
    req_data = 32'h0000_00C1;
    @(posedge clk);
    #1;
    checks++; if (tx_sending !== 1'b0) begin errors++;
      $display("FAIL reset_tx_sending: got %0b expected 0", tx_sending); end
    checks++; if (tx_data !== 8'h00) begin errors++;
      $display("FAIL reset_tx_data: got %0h expected 0", tx_data); end
    checks++; if (req_ready !== 4'b0000) begin errors++;
      $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL reset_busy: got %0b expected 1", busy); end
    checks++; if (grant_id !== 2'd3) begin errors++;
      $display("FAIL reset_grant_id: got %0d expected 3", grant_id); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel_cyc = cyc;
    ready_seen = 1'b0;
    repeat (99) begin
      @(negedge clk);
      if (req_ready !== 4'b0000) ready_seen = 1'b1;
    end
    checks++; if (ready_seen) begin errors++;
      $display("FAIL holdoff_ready: got asserted expected 0 for frame time"); end
    wait_xfer(250, ok, idx, e, rdy);
    checks++; if (!ok) begin errors++;
      $display("FAIL first_grant: got none expected grant"); end
    checks++; if (e - rel_cyc < 100 || e - rel_cyc > 101) begin errors++;
      $display("FAIL first_grant_time: got %0d expected 100..101", e - rel_cyc); end
    checks++; if (idx !== 0) begin errors++;
      $display("FAIL first_grant_idx: got %0d expected 0", idx); end
    checks++; if (tx_sending !== 1'b1) begin errors++;
      $display("FAIL send_strobe: got %0b expected 1", tx_sending); end
    checks++; if (tx_data !== 8'hC1) begin errors++;
      $display("FAIL send_data: got %0h expected c1", tx_data); end
    checks++; if (tx_data[0:1] !== 2'b11 || tx_data[7] !== 1'b1) begin errors++;
      $display("FAIL send_bit_order: got %b expected 11000001", tx_data); end
    req_valid = 4'b0000;
    @(posedge clk);
    #1;
    checks++; if (tx_sending !== 1'b0) begin errors++;
      $display("FAIL strobe_one_cycle: got %0b expected 0", tx_sending); end
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL busy_in_wait: got %0b expected 1", busy); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int idx, e, prev;
    logic [3:0] rdy;
    int exp_idx[5] = '{0, 1, 2, 3, 0};
    logic [7:0] bytes[4] = '{8'd15, 8'd121, 8'd170, 8'd255};
    req_data = {8'd255, 8'd170, 8'd121, 8'd15};
    do_reset(4'b1111);
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_xfer(300, ok, idx, e, rdy);
      checks++; if (!ok || idx != exp_idx[n]) begin errors++;
        $display("FAIL rr_order[%0d]: got %0d expected %0d", n, idx, exp_idx[n]); end
      checks++; if (tx_data !== bytes[exp_idx[n]]) begin errors++;
        $display("FAIL rr_data[%0d]: got %0d expected %0d", n, tx_data, bytes[exp_idx[n]]); end
      checks++; if (grant_id !== 2'(exp_idx[n])) begin errors++;
        $display("FAIL rr_grant_id[%0d]: got %0d expected %0d", n, grant_id, exp_idx[n]); end
      if (n > 0) begin
        checks++; if (e - prev != 100) begin errors++;
          $display("FAIL rr_period[%0d]: got %0d expected 100", n, e - prev); end
      end
      prev = e;
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_single();
    bit ok;
    int idx, e, prev;
    logic [3:0] rdy;
    req_data = 32'h004F_0000;
    do_reset(4'b0100);
    prev = 0;
    for (int n = 0; n < 3; n++) begin
      wait_xfer(300, ok, idx, e, rdy);
      checks++; if (!ok || rdy !== 4'b0100) begin errors++;
        $display("FAIL single_ready[%0d]: got %b expected 0100", n, rdy); end
      checks++; if (grant_id !== 2'd2 || tx_data !== 8'd79) begin errors++;
        $display("FAIL single_grant[%0d]: got id %0d data %0d expected id 2 data 79",
                 n, grant_id, tx_data); end
      if (n > 0) begin
        checks++; if (e - prev != 100) begin errors++;
          $display("FAIL single_period[%0d]: got %0d expected 100", n, e - prev); end
      end
      prev = e;
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int idx, e;
    logic [3:0] rdy;
    req_data = 32'h0000_005A;
    do_reset(4'b0001);
    wait_xfer(300, ok, idx, e, rdy);
    checks++; if (!ok || tx_sending !== 1'b1) begin errors++;
      $display("FAIL cut_setup: got strobe %0b expected 1", tx_sending); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (tx_sending !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin errors++;
      $display("FAIL cut_strobe: got sending %0b ready %b busy %0b expected 0 0000 1",
               tx_sending, req_ready, busy); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel_cyc = cyc;
    wait_xfer(300, ok, idx, e, rdy);
    checks++; if (!ok || e - rel_cyc < 100) begin errors++;
      $display("FAIL cut_regrant: got %0d cycles expected >= 100", e - rel_cyc); end
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (grant_id !== 2'd3 || tx_data !== 8'h00) begin errors++;
      $display("FAIL midwait_regs: got id %0d data %0h expected id 3 data 0", grant_id, tx_data); end
    checks++; if (tx_sending !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin errors++;
      $display("FAIL midwait_outs: got sending %0b ready %b busy %0b expected 0 0000 1",
               tx_sending, req_ready, busy); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel_cyc = cyc;
    wait_xfer(300, ok, idx, e, rdy);
    checks++; if (!ok || e - rel_cyc < 100) begin errors++;
      $display("FAIL midwait_regrant: got %0d cycles expected >= 100", e - rel_cyc); end
    req_valid = 4'b0000;
  endtask

  task automatic test_wait_masking();
    bit ok;
    int idx, e;
    logic [3:0] rdy;
    req_data = 32'h0000_003C;
    do_reset(4'b0001);
    wait_xfer(300, ok, idx, e, rdy);
    checks++; if (!ok || tx_data !== 8'h3C) begin errors++;
      $display("FAIL mask_setup: got %0h expected 3c", tx_data); end
    req_valid = 4'b0000;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    req_valid = 4'b0010;
    req_data = 32'h0000_5599;
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    checks++; if (req_ready !== 4'b0000) begin errors++;
      $display("FAIL mask_ready: got %b expected 0000", req_ready); end
    checks++; if (tx_data !== 8'h3C) begin errors++;
      $display("FAIL mask_data_wait: got %0h expected 3c", tx_data); end
    req_valid = 4'b0000;
    wait_xfer(200, ok, idx, e, rdy);
    checks++; if (ok) begin errors++;
      $display("FAIL mask_no_grant: got grant to %0d expected none", idx); end
    checks++; if (tx_data !== 8'h3C || grant_id !== 2'd0 || busy !== 1'b0) begin errors++;
      $display("FAIL mask_idle: got data %0h id %0d busy %0b expected 3c 0 0",
               tx_data, grant_id, busy); end
  endtask

  task automatic test_priority();
    bit ok;
    int idx, e, prev;
    logic [3:0] rdy;
`ifdef UART_SCHED_FIXED_PRIO_EN
    int exp_idx[3] = '{1, 1, 1};
`else
    int exp_idx[3] = '{1, 2, 1};
`endif
    req_data = 32'h00AA_BB00;
    do_reset(4'b0110);
    prev = 0;
    for (int n = 0; n < 3; n++) begin
      wait_xfer(300, ok, idx, e, rdy);
      checks++; if (!ok || idx != exp_idx[n]) begin errors++;
        $display("FAIL prio_order[%0d]: got %0d expected %0d", n, idx, exp_idx[n]); end
      if (n > 0) begin
        checks++; if (e - prev != 100) begin errors++;
          $display("FAIL prio_period[%0d]: got %0d expected 100", n, e - prev); end
      end
      prev = e;
    end
    req_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_reset_mid_frame();
    test_wait_masking();
    test_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
